// File: rtl/host_output_dispatch.sv
// Read side of the host input queue. It owns the 32-slot TS descriptor RAM and its bitmap, and it dispatches TS and NTS descriptors one at a time.
// A trigger reaches o_desc_valid two edges later. The FSM holds in SEND until i_desc_ready is seen, and TS preempts NTS at every IDLE decision.
module host_output_dispatch (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [12:0] iv_ts_descriptor_wdata,
  input  logic        i_ts_descriptor_wr,
  input  logic [4:0]  iv_ts_descriptor_waddr,
  input  logic        i_ts_submit_pulse,
  input  logic [4:0]  iv_ts_submit_addr,
  input  logic [12:0] iv_nts_fifo_rdata,
  input  logic        i_nts_fifo_empty,
  output logic        o_nts_fifo_rd,
  output logic [8:0]  ov_bufid,
  output logic [3:0]  ov_inport,
  output logic        o_desc_ts,
  output logic        o_desc_valid,
  input  logic        i_desc_ready,
  output logic [8:0]  ov_free_bufid,
  output logic        o_free_bufid_wr,
  output logic [31:0] ov_ts_cnt,
  output logic        o_ts_miss_pulse,
  output logic        o_ts_overwrite_pulse,
  output logic [15:0] ov_debug_ts_cnt,
  output logic [15:0] ov_debug_nts_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t      state, state_n;
  logic [12:0] ts_ram [32];
  logic [31:0] pending, pending_n;
  logic [31:0] ts_cnt_n;
  logic [4:0]  sel_idx;
  logic        ts_take, nts_take, nts_pop, nts_free, handshake;
  logic        clr_same_w, clr_same_s, wr_same_s;
  logic        miss_n, overwrite_n;

  // Lowest pending slot wins.
  always_comb begin
    sel_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pending[i]) sel_idx = 5'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ts_take   = 1'b0;
    nts_take  = 1'b0;
    nts_pop   = 1'b0;
    nts_free  = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          ts_take = 1'b1;
          state_n = SEND;
        end else if (!i_nts_fifo_empty) begin
          nts_pop = 1'b1;
          if (iv_nts_fifo_rdata[12:9] == 4'hf) begin
            nts_free = 1'b1;
            state_n  = WAIT;
          end else begin
            nts_take = 1'b1;
            state_n  = SEND;
          end
        end
      end
      SEND: begin
        if (o_desc_valid && i_desc_ready) begin
          handshake = 1'b1;
          state_n   = IDLE;
        end
      end
      WAIT:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A dispatch clear and a write or trigger may hit the same slot in one cycle.
  // The write always survives, and a trigger re-arms the slot only if it is refilled.
  always_comb begin
    clr_same_w  = ts_take && (sel_idx == iv_ts_descriptor_waddr);
    clr_same_s  = ts_take && (sel_idx == iv_ts_submit_addr);
    wr_same_s   = i_ts_descriptor_wr && (iv_ts_descriptor_waddr == iv_ts_submit_addr);
    ts_cnt_n    = ov_ts_cnt;
    pending_n   = pending;
    if (ts_take) begin
      ts_cnt_n[sel_idx]  = 1'b0;
      pending_n[sel_idx] = 1'b0;
    end
    if (i_ts_descriptor_wr) ts_cnt_n[iv_ts_descriptor_waddr] = 1'b1;
    if (i_ts_submit_pulse && ov_ts_cnt[iv_ts_submit_addr] && (!clr_same_s || wr_same_s))
      pending_n[iv_ts_submit_addr] = 1'b1;
    miss_n      = i_ts_submit_pulse && !ov_ts_cnt[iv_ts_submit_addr];
    overwrite_n = i_ts_descriptor_wr && ov_ts_cnt[iv_ts_descriptor_waddr] && !clr_same_w;
  end

  // RAM contents need no reset because the bitmap gates every read.
  always_ff @(posedge i_clk) begin
    if (i_ts_descriptor_wr) ts_ram[iv_ts_descriptor_waddr] <= iv_ts_descriptor_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_ts_cnt            <= '0;
      pending              <= '0;
      o_nts_fifo_rd        <= 1'b0;
      ov_bufid             <= '0;
      ov_inport            <= '0;
      o_desc_ts            <= 1'b0;
      o_desc_valid         <= 1'b0;
      ov_free_bufid        <= '0;
      o_free_bufid_wr      <= 1'b0;
      o_ts_miss_pulse      <= 1'b0;
      o_ts_overwrite_pulse <= 1'b0;
      ov_debug_ts_cnt      <= '0;
      ov_debug_nts_cnt     <= '0;
    end else begin
      ov_ts_cnt            <= ts_cnt_n;
      pending              <= pending_n;
      o_nts_fifo_rd        <= nts_pop;
      o_free_bufid_wr      <= nts_free;
      o_ts_miss_pulse      <= miss_n;
      o_ts_overwrite_pulse <= overwrite_n;
      if (nts_free) ov_free_bufid <= iv_nts_fifo_rdata[8:0];
      if (ts_take) begin
        ov_bufid     <= ts_ram[sel_idx][8:0];
        ov_inport    <= ts_ram[sel_idx][12:9];
        o_desc_ts    <= 1'b1;
        o_desc_valid <= 1'b1;
      end else if (nts_take) begin
        ov_bufid     <= iv_nts_fifo_rdata[8:0];
        ov_inport    <= iv_nts_fifo_rdata[12:9];
        o_desc_ts    <= 1'b0;
        o_desc_valid <= 1'b1;
      end else if (handshake) begin
        o_desc_valid <= 1'b0;
      end
      if (handshake) begin
        if (o_desc_ts) ov_debug_ts_cnt  <= ov_debug_ts_cnt + 16'd1;
        else           ov_debug_nts_cnt <= ov_debug_nts_cnt + 16'd1;
      end
    end
  end

endmodule
